// File: rtl/rom_port_arbiter_if.sv
// Bundle of the fetch/data-load request and response handshakes plus the ROM read port.
// The arbiter sits on the slave side; requesters and the ROM model sit on the master side.
interface rom_port_arbiter_if;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_resp_valid;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport slave (
        input  f_req_valid, f_req_addr, d_req_valid, d_req_addr, mem_rdata,
        output f_req_ready, f_resp_valid, d_req_ready, d_resp_valid,
        output resp_rdata, resp_err, mem_addr
    );

    modport master (
        output f_req_valid, f_req_addr, d_req_valid, d_req_addr, mem_rdata,
        input  f_req_ready, f_resp_valid, d_req_ready, d_resp_valid,
        input  resp_rdata, resp_err, mem_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one ROM read port between fetch (F) and data-load (D).
// Bad addresses are answered with an error response without touching the ROM.
module rom_port_arbiter #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      DEPTH_W  = 32'(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;   // 0: F has priority, 1: D has priority
    logic             gnt_q, gnt_d;   // 0: F granted, 1: D granted
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             f_rv_q, f_rv_d;
    logic             d_rv_q, d_rv_d;

    logic             can_acc, sel_f, sel_d, f_ready, d_ready, accept, addr_ok;
    logic [31:0]      req_addr;

    always_comb begin
        can_acc  = (state_q == IDLE) || (state_q == RESP);
        sel_f    = bus.f_req_valid & (~bus.d_req_valid | ~ptr_q);
        sel_d    = bus.d_req_valid & (~bus.f_req_valid | ptr_q);
        f_ready  = can_acc & sel_f;
        d_ready  = can_acc & sel_d;
        accept   = f_ready | d_ready;
        req_addr = sel_d ? bus.d_req_addr : bus.f_req_addr;
        addr_ok  = (req_addr[1:0] == 2'b00) && ({2'b00, req_addr[31:2]} < DEPTH_W);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        f_rv_d     = 1'b0;
        d_rv_d     = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    gnt_d = sel_d;
                    ptr_d = ~sel_d;
                    if (addr_ok) begin
                        mem_addr_d = req_addr;
                        cnt_d      = CNT_LOAD;
                        state_d    = BUSY;
                    end else begin
                        // Rejected: answer next cycle, ROM address left alone.
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        f_rv_d  = ~sel_d;
                        d_rv_d  = sel_d;
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    f_rv_d  = ~gnt_q;
                    d_rv_d  = gnt_q;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            mem_addr_q <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            f_rv_q     <= 1'b0;
            d_rv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            f_rv_q     <= f_rv_d;
            d_rv_q     <= d_rv_d;
        end
    end

    assign bus.f_req_ready  = f_ready;
    assign bus.d_req_ready  = d_ready;
    assign bus.f_resp_valid = f_rv_q;
    assign bus.d_resp_valid = d_rv_q;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_err     = err_q;
    assign bus.mem_addr     = mem_addr_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: one instance at LATENCY=1, one at LATENCY=3, shared ROM model.
module tb_rom_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rom_port_arbiter_if b1 ();
    rom_port_arbiter_if b3 ();

    rom_port_arbiter #(.LATENCY(1), .DEPTH(64)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    rom_port_arbiter #(.LATENCY(3), .DEPTH(64)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        case (idx)
            30'd3:   return 32'h0010_0093;
            30'd4:   return 32'h00B0_0113;
            30'd5:   return 32'h0000_0193;
            30'd6:   return 32'h0010_8093;
            30'd63:  return 32'h0FF0_0F13;
            default: return 32'hA5A5_0000 | {2'b00, idx};
        endcase
    endfunction

    assign b1.mem_rdata = rom_word(b1.mem_addr[31:2]);
    assign b3.mem_rdata = rom_word(b3.mem_addr[31:2]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b1.f_req_valid = 1'b0; b1.f_req_addr = 32'h0; b1.d_req_valid = 1'b0; b1.d_req_addr = 32'h0;
        b3.f_req_valid = 1'b0; b3.f_req_addr = 32'h0; b3.d_req_valid = 1'b0; b3.d_req_addr = 32'h0;
        #2;
        check("rst_mem_addr", b1.mem_addr, 32'h0);
        check("rst_rdata", b1.resp_rdata, 32'h0);
        check("rst_err", 32'(b1.resp_err), 32'h0);
        check("rst_f_rv", 32'(b1.f_resp_valid), 32'h0);
        check("rst_d_rv", 32'(b1.d_resp_valid), 32'h0);
        tick();
        rst_n = 1'b1;

        // Single good fetch, LATENCY=1
        b1.f_req_valid = 1'b1; b1.f_req_addr = 32'h0C;
        #1;
        check("t1_f_ready", 32'(b1.f_req_ready), 32'h1);
        check("t1_d_ready", 32'(b1.d_req_ready), 32'h0);
        tick();
        b1.f_req_valid = 1'b0;
        check("t1_mem_addr", b1.mem_addr, 32'h0C);
        check("t1_f_rv_busy", 32'(b1.f_resp_valid), 32'h0);
        tick();
        check("t1_f_rv", 32'(b1.f_resp_valid), 32'h1);
        check("t1_d_rv", 32'(b1.d_resp_valid), 32'h0);
        check("t1_rdata", b1.resp_rdata, 32'h0010_0093);
        check("t1_err", 32'(b1.resp_err), 32'h0);
        tick();
        check("t1_f_rv_after", 32'(b1.f_resp_valid), 32'h0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Both ports continuously valid: F, D, F, D
        b1.f_req_valid = 1'b1; b1.f_req_addr = 32'h10;
        b1.d_req_valid = 1'b1; b1.d_req_addr = 32'h14;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic is_d;
            is_d = i[0];
            check("t2_f_ready", 32'(b1.f_req_ready), 32'(!is_d));
            check("t2_d_ready", 32'(b1.d_req_ready), 32'(is_d));
            tick();
            check("t2_mem_addr", b1.mem_addr, is_d ? 32'h14 : 32'h10);
            check("t2_busy_ready", {30'h0, b1.f_req_ready, b1.d_req_ready}, 32'h0);
            tick();
            check("t2_f_rv", 32'(b1.f_resp_valid), 32'(!is_d));
            check("t2_d_rv", 32'(b1.d_resp_valid), 32'(is_d));
            check("t2_rdata", b1.resp_rdata, is_d ? 32'h0000_0193 : 32'h00B0_0113);
        end
        b1.f_req_valid = 1'b0; b1.d_req_valid = 1'b0;
        tick();

        // Misaligned data load
        b1.d_req_valid = 1'b1; b1.d_req_addr = 32'h0E;
        #1;
        check("t3_d_ready", 32'(b1.d_req_ready), 32'h1);
        check("t3_f_ready", 32'(b1.f_req_ready), 32'h0);
        tick();
        b1.d_req_valid = 1'b0;
        check("t3_d_rv", 32'(b1.d_resp_valid), 32'h1);
        check("t3_err", 32'(b1.resp_err), 32'h1);
        check("t3_rdata", b1.resp_rdata, 32'h0);
        check("t3_mem_addr", b1.mem_addr, 32'h14);
        tick();
        check("t3_d_rv_after", 32'(b1.d_resp_valid), 32'h0);

        // Out of range, then last valid word
        b1.f_req_valid = 1'b1; b1.f_req_addr = 32'h100;
        #1;
        check("t4_f_ready_oor", 32'(b1.f_req_ready), 32'h1);
        tick();
        b1.f_req_valid = 1'b0;
        check("t4_f_rv_oor", 32'(b1.f_resp_valid), 32'h1);
        check("t4_err_oor", 32'(b1.resp_err), 32'h1);
        check("t4_mem_addr_oor", b1.mem_addr, 32'h14);
        tick();
        b1.f_req_valid = 1'b1; b1.f_req_addr = 32'hFC;
        #1;
        check("t4_f_ready_63", 32'(b1.f_req_ready), 32'h1);
        tick();
        b1.f_req_valid = 1'b0;
        check("t4_mem_addr_63", b1.mem_addr, 32'hFC);
        tick();
        check("t4_f_rv_63", 32'(b1.f_resp_valid), 32'h1);
        check("t4_err_63", 32'(b1.resp_err), 32'h0);
        check("t4_rdata_63", b1.resp_rdata, 32'h0FF0_0F13);
        tick();

        // LATENCY=3: address held, D blocked during BUSY
        b3.f_req_valid = 1'b1; b3.f_req_addr = 32'h18;
        b3.d_req_valid = 1'b1; b3.d_req_addr = 32'h14;
        #1;
        check("t5_f_ready", 32'(b3.f_req_ready), 32'h1);
        check("t5_d_ready", 32'(b3.d_req_ready), 32'h0);
        tick();
        b3.f_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check("t5_mem_addr", b3.mem_addr, 32'h18);
            check("t5_d_ready_busy", 32'(b3.d_req_ready), 32'h0);
            check("t5_f_rv_busy", 32'(b3.f_resp_valid), 32'h0);
            tick();
        end
        check("t5_f_rv", 32'(b3.f_resp_valid), 32'h1);
        check("t5_rdata", b3.resp_rdata, 32'h0010_8093);
        check("t5_d_ready_resp", 32'(b3.d_req_ready), 32'h1);
        tick();
        b3.d_req_valid = 1'b0;
        check("t5_f_rv_after", 32'(b3.f_resp_valid), 32'h0);
        check("t5_mem_addr_d", b3.mem_addr, 32'h14);
        tick();
        tick();
        tick();
        check("t5_d_rv", 32'(b3.d_resp_valid), 32'h1);
        check("t5_d_rdata", b3.resp_rdata, 32'h0000_0193);
        tick();

        // Asynchronous reset while BUSY
        b3.f_req_valid = 1'b1; b3.f_req_addr = 32'h0C;
        #1;
        check("t6_f_ready", 32'(b3.f_req_ready), 32'h1);
        tick();
        b3.f_req_valid = 1'b0;
        check("t6_mem_addr_busy", b3.mem_addr, 32'h0C);
        rst_n = 1'b0;
        #1;
        check("t6_async_mem_addr", b3.mem_addr, 32'h0);
        check("t6_async_rdata", b3.resp_rdata, 32'h0);
        check("t6_async_err", 32'(b3.resp_err), 32'h0);
        check("t6_async_rv", {30'h0, b3.f_resp_valid, b3.d_resp_valid}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t6_no_resp", {30'h0, b3.f_resp_valid, b3.d_resp_valid}, 32'h0);
            tick();
        end
        b3.f_req_valid = 1'b1; b3.f_req_addr = 32'h0C;
        b3.d_req_valid = 1'b1; b3.d_req_addr = 32'h10;
        #1;
        check("t6_post_f_ready", 32'(b3.f_req_ready), 32'h1);
        check("t6_post_d_ready", 32'(b3.d_req_ready), 32'h0);
        tick();
        b3.f_req_valid = 1'b0; b3.d_req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t6_post_f_rv", 32'(b3.f_resp_valid), 32'h1);
        check("t6_post_rdata", b3.resp_rdata, 32'h0010_0093);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single read port of the word-addressed instruction ROM between two requesters: instruction fetch (port F) and data load (port D). Each request goes through a valid/ready handshake. The arbiter grants round-robin, drives a stable word address to the ROM for a configurable latency, captures the read word and returns it with a one-cycle response pulse to the granted port. Misaligned and out-of-range addresses are rejected without a ROM access.

## Interface
- LATENCY, 1, cycles the ROM address is held before read data is sampled (≥1)
- DEPTH, 64, ROM depth in 32-bit words; valid word indices 0..DEPTH-1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request present
- f_req_addr  in  32  fetch byte address
- f_req_ready  out  1  fetch request accepted this cycle when high with f_req_valid
- f_resp_valid  out  1  one-cycle pulse: response for port F on resp_rdata/resp_err
- d_req_valid  in  1  data-load request present
- d_req_addr  in  32  data-load byte address
- d_req_ready  out  1  data-load request accepted this cycle when high with d_req_valid
- d_resp_valid  out  1  one-cycle pulse: response for port D
- resp_rdata  out  32  read word (shared by both ports)
- resp_err  out  1  response is an error (misaligned or out of range)
- mem_addr  out  32  byte address to ROM (ROM indexes by mem_addr[31:2])
- mem_rdata  in  32  combinational ROM read data

## Operation
- Reset is asynchronous, active-low, and needs one clock and reset only. Reset values: state IDLE; mem_addr=0; resp_rdata=0; resp_err=0; f_resp_valid=d_resp_valid=0; round-robin pointer = F.
- FSM states: IDLE, BUSY, RESP.
- f_req_ready/d_req_ready are combinational. They are high only in IDLE or RESP, and only for the port currently chosen by arbitration. At most one ready is high per cycle.
- Arbitration:
  - Exactly one port valid → that port is chosen.
  - Both ports valid → the port named by the pointer is chosen.
  - After an accept, the pointer moves to the port that was not granted.
  - The pointer does not change when nothing is accepted.
- Accept means the chosen port has valid & ready at a rising edge.
- On accept, the arbiter checks the address:
  - Address good (addr[1:0]==0 and addr[31:2] < DEPTH): register mem_addr=addr, load counter=LATENCY, go to BUSY, record the granted port.
  - Address bad: mem_addr is unchanged, go directly to RESP with resp_err=1 and resp_rdata=0.
- BUSY:
  - Counter decrements each cycle.
  - At the edge where the counter equals 1, capture resp_rdata=mem_rdata and resp_err=0, then go to RESP.
- RESP:
  - The resp_valid of the granted port is high for exactly this cycle.
  - resp_rdata/resp_err hold their values until the next response is captured.
- Leaving RESP: if a new request is accepted in RESP, handle it exactly as an accept from IDLE (BUSY or RESP next). Otherwise go to IDLE.
- Requesters must keep req_valid and req_addr stable until accepted. An un-accepted request is never lost.
- mem_addr is stable from the cycle after accept through the capture edge. It keeps its last value in IDLE.
- Reset mid-operation: all state clears immediately and the pending request is dropped with no response. The requester must re-issue it.

## Timing
- Good request accepted at edge 0:
  - mem_addr valid from cycle 1.
  - resp_rdata captured at edge LATENCY.
  - resp_valid high during cycle LATENCY+1 (between edges LATENCY and LATENCY+1).
- Bad request accepted at edge 0: resp_valid with resp_err=1 during cycle 1.
- Back-to-back good requests: one accept per LATENCY+1 cycles, since the next accept happens in the RESP cycle.
- Both ports continuously valid: grants alternate F, D, F, D, …, with the first grant after reset going to F.
- Responses return in grant order; each port has at most one request outstanding.

## Test plan
- ROM word 3=0x00100093, LATENCY=1. F requests 0x0C → f_req_ready=1 at edge 0; mem_addr=0x0C in cycle 1; f_resp_valid=1 and resp_rdata=0x00100093, resp_err=0 in cycle 2.
- F and D both valid continuously, F=0x10 and D=0x14, word4=0x00B00113, word5=0x00000193 → grants F, D, F, D; responses 0x00B00113, 0x00000193 alternate, one every 2 cycles.
- D requests 0x0E (misaligned) → D accepted; d_resp_valid=1, resp_err=1, resp_rdata=0 in the next cycle; mem_addr unchanged.
- DEPTH=64, F requests 0x100 → resp_err=1; then F requests 0xFC → resp_err=0 with the word-63 contents.
- LATENCY=3, F requests 0x18 (word6=0x00108093) → mem_addr held at 0x18 for cycles 1..3; f_resp_valid only in cycle 4; d_req_ready stays 0 during BUSY while d_req_valid=1; D is accepted in cycle 4.
- rst_n pulled low in BUSY → outputs return to reset values asynchronously; no resp_valid pulse; after release, F is granted first and returns correct data.
